// File: rtl/simple_bist_ctrl.sv
// ---------------------------------------------------------------------------
// simple_bist_ctrl
//
// Built-in self-test controller for the `simple` netlist. A right-shifting
// Galois LFSR produces pseudo-random patterns for the two netlist inputs, and
// a left-shifting MISR compacts the netlist output into a 16-bit signature.
// At the end of a run the signature is compared against GOLDEN_SIG, so that
// original and enhanced netlists can be checked for equivalence in-system.
//
// Sequence per run: IDLE -> FLUSH (2) -> RUN (PATTERN_COUNT) -> DRAIN (1) -> DONE
//
// Ports
//   iccad_clk    in   1   clock, all state on rising edge
//   iccad_rst_n  in   1   asynchronous active-low reset
//   start        in   1   run request, sampled only in IDLE or DONE
//   out_dut      in   1   netlist output `out`
//   inp1, inp2   out  1   netlist inputs (registered)
//   busy         out  1   high in FLUSH, RUN and DRAIN
//   done         out  1   high in DONE
//   pass         out  1   signature matched GOLDEN_SIG (valid while done)
//   signature    out  16  MISR contents
// ---------------------------------------------------------------------------
module simple_bist_ctrl #(
  parameter int unsigned PATTERN_COUNT = 256,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter logic [15:0] LFSR_POLY     = 16'hB400,
  parameter logic [15:0] MISR_POLY     = 16'h1021,
  parameter logic [15:0] GOLDEN_SIG    = 16'h0000
) (
  input  logic        iccad_clk,
  input  logic        iccad_rst_n,
  input  logic        start,
  input  logic        out_dut,
  output logic        inp1,
  output logic        inp2,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LAST_CNT = 16'(PATTERN_COUNT - 1);

  state_t      r_state;
  logic [15:0] r_lfsr;
  logic [15:0] r_sig;
  logic [15:0] r_cnt;
  logic        r_flush;
  logic        r_inp1;
  logic        r_inp2;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;

  logic [15:0] w_lfsr_step;
  logic [15:0] w_misr_step;

  assign w_lfsr_step = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_POLY : 16'h0000);
  assign w_misr_step = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? MISR_POLY : 16'h0000)
                     ^ {15'b0, out_dut};

  always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
    if (!iccad_rst_n) begin
      r_state <= ST_IDLE;
      r_lfsr  <= SEED_EFF;
      r_sig   <= 16'h0000;
      r_cnt   <= 16'h0000;
      r_flush <= 1'b0;
      r_inp1  <= 1'b0;
      r_inp2  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_FLUSH;
            r_lfsr  <= SEED_EFF;
            r_sig   <= 16'h0000;
            r_cnt   <= 16'h0000;
            r_flush <= 1'b0;
            r_inp1  <= 1'b0;
            r_inp2  <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end

        // Two cycles of inp1=inp2=0 force the netlist flop to a known 0.
        ST_FLUSH: begin
          r_flush <= 1'b1;
          if (r_flush) begin
            r_state <= ST_RUN;
            // Inputs are registered, so preload the first pattern here.
            r_inp1  <= r_lfsr[0];
            r_inp2  <= r_lfsr[1];
          end
        end

        ST_RUN: begin
          r_lfsr <= w_lfsr_step;
          r_sig  <= w_misr_step;
          r_cnt  <= r_cnt + 16'd1;
          if (r_cnt == LAST_CNT) begin
            r_state <= ST_DRAIN;
            r_inp1  <= 1'b0;
            r_inp2  <= 1'b0;
          end else begin
            r_inp1  <= w_lfsr_step[0];
            r_inp2  <= w_lfsr_step[1];
          end
        end

        // The netlist has one flop of latency: this sample is the response
        // to the last RUN pattern.
        ST_DRAIN: begin
          r_sig   <= w_misr_step;
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= (w_misr_step == GOLDEN_SIG);
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign inp1      = r_inp1;
  assign inp2      = r_inp2;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_sig;

endmodule

// File: tb/tb_simple_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_simple_bist_ctrl
//
// Directed bench for simple_bist_ctrl. Three instances:
//   dut_a : defaults (256 patterns, seed ACE1, golden 0); out_dut from either
//           a tie-off or a small AND-flop stand-in for the netlist
//   dut_b : PATTERN_COUNT=1, out_dut tied 1
//   dut_c : LFSR_SEED=0, PATTERN_COUNT=4, out_dut tied 0
// ---------------------------------------------------------------------------
module tb_simple_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic use_net = 1'b0;
  logic tie_a = 1'b0;
  logic net_q;
  logic out_a, out_b, out_c;

  logic a_inp1, a_inp2, a_busy, a_done, a_pass;
  logic b_inp1, b_inp2, b_busy, b_done, b_pass;
  logic c_inp1, c_inp2, c_busy, c_done, c_pass;
  logic [15:0] a_sig, b_sig, c_sig;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] inp_log [0:15];

  always #5 clk = ~clk;

  // Stand-in netlist: one flop capturing inp1 & inp2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) net_q <= 1'b0;
    else        net_q <= a_inp1 & a_inp2;
  end

  assign out_a = use_net ? net_q : tie_a;
  assign out_b = 1'b1;
  assign out_c = 1'b0;

  simple_bist_ctrl dut_a (
    .iccad_clk(clk), .iccad_rst_n(rst_n), .start(start_a), .out_dut(out_a),
    .inp1(a_inp1), .inp2(a_inp2), .busy(a_busy), .done(a_done), .pass(a_pass),
    .signature(a_sig)
  );

  simple_bist_ctrl #(.PATTERN_COUNT(1)) dut_b (
    .iccad_clk(clk), .iccad_rst_n(rst_n), .start(start_b), .out_dut(out_b),
    .inp1(b_inp1), .inp2(b_inp2), .busy(b_busy), .done(b_done), .pass(b_pass),
    .signature(b_sig)
  );

  simple_bist_ctrl #(.PATTERN_COUNT(4), .LFSR_SEED(16'h0000)) dut_c (
    .iccad_clk(clk), .iccad_rst_n(rst_n), .start(start_c), .out_dut(out_c),
    .inp1(c_inp1), .inp2(c_inp2), .busy(c_busy), .done(c_done), .pass(c_pass),
    .signature(c_sig)
  );

  // Reference signature for dut_a driven by the AND-flop netlist.
  function automatic logic [15:0] model_sig(input logic [15:0] seed, input int n);
    logic [15:0] l, s;
    logic q;
    l = seed;
    s = 16'h0000;
    q = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, q};
      q = l[0] & l[1];
      l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    end
    s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, q};
    return s;
  endfunction

  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  // Samples at each negedge until done; counts busy cycles and logs the
  // inputs of the first samples. Optional extra start pulses (p1/p2) and a
  // one-cycle out_dut glitch (flip_k) on dut_a, keyed by busy-sample number.
  task automatic run_mon(input int which, input int p1, input int p2, input int flip_k,
                         output int nbusy, output bit got_done);
    logic bz, dn, i1, i2;
    nbusy = 0;
    got_done = 1'b0;
    for (int i = 0; i < 16; i++) inp_log[i] = 2'b11;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      start_a = 1'b0;
      tie_a   = 1'b0;
      case (which)
        0:       begin bz = a_busy; dn = a_done; i1 = a_inp1; i2 = a_inp2; end
        1:       begin bz = b_busy; dn = b_done; i1 = b_inp1; i2 = b_inp2; end
        default: begin bz = c_busy; dn = c_done; i1 = c_inp1; i2 = c_inp2; end
      endcase
      if (dn) begin
        got_done = 1'b1;
        break;
      end
      if (bz) nbusy++;
      if (nbusy < 16) inp_log[nbusy] = {i2, i1};
      if (which == 0 && (nbusy == p1 || nbusy == p2)) start_a = 1'b1;
      if (which == 0 && nbusy == flip_k) tie_a = 1'b1;
    end
    if (!got_done) begin
      n_tests++; n_fail++;
      $display("FAIL run_timeout dut=%0d busy_seen=%0d required done within 2000 cycles", which, nbusy);
    end
    $display("[TB] run dut=%0d busy_cycles=%0d done=%0b", which, nbusy, got_done);
  endtask

  task automatic test_reset();
    int nb;
    #1;
    n_tests++;
    if ({a_inp1, a_inp2, a_busy, a_done, a_pass, a_sig} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_state got inp=%b%b busy=%b done=%b pass=%b sig=%h required all 0",
               a_inp1, a_inp2, a_busy, a_done, a_pass, a_sig);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (a_busy !== 1'b0 || a_done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_start got busy=%b done=%b required 0 0", a_busy, a_done);
    end
    // Reset mid-RUN
    pulse(0);
    repeat (12) @(negedge clk);
    n_tests++;
    if (a_busy !== 1'b1 || a_sig === 16'hxxxx) begin
      n_fail++;
      $display("FAIL midrun_busy got busy=%b required 1", a_busy);
    end
    #2 rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({a_inp1, a_inp2, a_busy, a_done, a_pass, a_sig} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_midrun got inp=%b%b busy=%b done=%b pass=%b sig=%h required all 0",
               a_inp1, a_inp2, a_busy, a_done, a_pass, a_sig);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (a_busy !== 1'b0 || a_sig !== 16'h0000) begin
      n_fail++;
      $display("FAIL after_reset_idle got busy=%b sig=%h required 0 0000", a_busy, a_sig);
    end
    nb = 0;
  endtask

  task automatic test_single_pattern();
    int nb; bit ok;
    pulse(1);
    run_mon(1, -1, -1, -1, nb, ok);
    n_tests++;
    if (nb !== 4) begin
      n_fail++;
      $display("FAIL n1_busy_cycles got %0d required 4", nb);
    end
    n_tests++;
    if (b_sig !== 16'h0003 || b_done !== 1'b1 || b_pass !== 1'b0) begin
      n_fail++;
      $display("FAIL n1_signature got sig=%h done=%b pass=%b required 0003 1 0", b_sig, b_done, b_pass);
    end
  endtask

  task automatic test_zero_response();
    int nb; bit ok;
    use_net = 1'b0;
    pulse(0);
    run_mon(0, -1, -1, -1, nb, ok);
    n_tests++;
    if (nb !== 259) begin
      n_fail++;
      $display("FAIL zero_busy_cycles got %0d required 259", nb);
    end
    n_tests++;
    if (a_sig !== 16'h0000 || a_pass !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_pass got sig=%h pass=%b required 0000 1", a_sig, a_pass);
    end
    // inp_log holds {inp2,inp1}: FLUSH 00,00; RUN from ACE1: 01,00,00,00,10
    n_tests++;
    if (inp_log[1] !== 2'b00 || inp_log[2] !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_inputs got %b %b required 00 00", inp_log[1], inp_log[2]);
    end
    n_tests++;
    if (inp_log[3] !== 2'b01 || inp_log[4] !== 2'b00 || inp_log[7] !== 2'b10) begin
      n_fail++;
      $display("FAIL run_patterns got p1=%b p2=%b p5=%b required 01 00 10",
               inp_log[3], inp_log[4], inp_log[7]);
    end
  endtask

  task automatic test_netlist();
    int nb; bit ok;
    logic [15:0] exp_sig;
    exp_sig = model_sig(16'hACE1, 256);
    use_net = 1'b1;
    pulse(0);
    run_mon(0, -1, -1, -1, nb, ok);
    n_tests++;
    if (a_sig !== exp_sig) begin
      n_fail++;
      $display("FAIL netlist_signature got %h required %h", a_sig, exp_sig);
    end
    use_net = 1'b0;
    // One corrupted RUN sample on an otherwise all-zero response.
    pulse(0);
    run_mon(0, -1, -1, 50, nb, ok);
    n_tests++;
    if (a_pass !== 1'b0 || a_sig === 16'h0000) begin
      n_fail++;
      $display("FAIL flipped_sample got pass=%b sig=%h required pass 0 and sig nonzero", a_pass, a_sig);
    end
  endtask

  task automatic test_start_while_busy();
    int nb; bit ok;
    pulse(0);
    run_mon(0, 1, 40, -1, nb, ok);
    n_tests++;
    if (nb !== 259 || a_sig !== 16'h0000) begin
      n_fail++;
      $display("FAIL start_ignored got busy=%0d sig=%h required 259 0000", nb, a_sig);
    end
  endtask

  task automatic test_back_to_back();
    int nb; bit ok;
    pulse(0);
    run_mon(0, -1, -1, -1, nb, ok);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n_tests++;
    if (a_done !== 1'b0 || a_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_from_done got done=%b busy=%b required 0 1", a_done, a_busy);
    end
    run_mon(0, -1, -1, -1, nb, ok);
    n_tests++;
    if (nb !== 258 || a_pass !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_run got remaining_busy=%0d pass=%b required 258 1", nb, a_pass);
    end
  endtask

  task automatic test_zero_seed();
    int nb; bit ok;
    pulse(2);
    run_mon(2, -1, -1, -1, nb, ok);
    n_tests++;
    if (inp_log[3] !== 2'b01 || inp_log[4] !== 2'b00) begin
      n_fail++;
      $display("FAIL zero_seed got p1=%b p2=%b required 01 00", inp_log[3], inp_log[4]);
    end
    n_tests++;
    if (nb !== 7 || c_pass !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_seed_run got busy=%0d pass=%b required 7 1", nb, c_pass);
    end
  endtask

  initial begin
    test_reset();
    test_single_pattern();
    test_zero_response();
    test_netlist();
    test_start_while_busy();
    test_back_to_back();
    test_zero_seed();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
